// File: rtl/spiflash_pkg.sv
// +----------------------------------------------------------------------+
// | spiflash_pkg : opcodes, state encoding and helpers for spiflash_rdctl |
// | rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

package spiflash_pkg;

  localparam logic [7:0] CMD_WAKE  = 8'hAB;
  localparam logic [7:0] CMD_READ  = 8'h03;
  localparam logic [6:0] WAKE_BITS = 7'd8;
  localparam logic [6:0] XFER_BITS = 7'd64;

  typedef enum logic [2:0] {
    WAKE = 3'd0,
    GAP  = 3'd1,
    IDLE = 3'd2,
    XFER = 3'd3,
    DONE = 3'd4
  } state_t;

  // First byte off the wire becomes the least significant byte.
  function automatic logic [31:0] bswap32(input logic [31:0] w);
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction

endpackage

`default_nettype wire

// File: rtl/spiflash_shift.sv
// +----------------------------------------------------------------------+
// | spiflash_shift : SCLK divider, bit counter and tx/rx shift registers |
// | rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module spiflash_shift #(
  parameter int CLKDIV = 1
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        start,
  input  logic [6:0]  nbits,
  input  logic [31:0] tx_data,
  input  logic        miso,
  output logic        sclk,
  output logic        mosi,
  output logic        busy,
  output logic        done,
  output logic [31:0] rx_data
);

  logic        r_busy;
  logic        r_sclk;
  logic [7:0]  r_div;
  logic [6:0]  r_bit;
  logic [31:0] r_tx;
  logic [31:0] r_rx;
  logic        w_tick;

  assign w_tick  = r_busy && (r_div == 8'(CLKDIV - 1));
  // Asserted on the edge that ends the last high phase, so the caller can
  // raise chip select on the very same edge.
  assign done    = w_tick && r_sclk && (r_bit == nbits - 7'd1);
  assign sclk    = r_sclk;
  assign mosi    = r_busy & r_tx[31];
  assign busy    = r_busy;
  assign rx_data = r_rx;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_busy <= 1'b0;
      r_sclk <= 1'b0;
      r_div  <= 8'd0;
      r_bit  <= 7'd0;
      r_tx   <= 32'd0;
      r_rx   <= 32'd0;
    end else if (start) begin
      r_busy <= 1'b1;
      r_sclk <= 1'b0;
      r_div  <= 8'd0;
      r_bit  <= 7'd0;
      r_tx   <= tx_data;
    end else if (r_busy) begin
      if (w_tick) begin
        r_div  <= 8'd0;
        r_sclk <= ~r_sclk;
        if (!r_sclk) begin
          r_rx <= {r_rx[30:0], miso};
        end else begin
          // Falling edge: next bit presented while SCLK is low.
          r_tx <= {r_tx[30:0], 1'b0};
          if (done) begin
            r_busy <= 1'b0;
            r_bit  <= 7'd0;
          end else begin
            r_bit <= r_bit + 7'd1;
          end
        end
      end else begin
        r_div <= r_div + 8'd1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/spiflash_rdctl.sv
// +----------------------------------------------------------------------+
// | spiflash_rdctl : wakes a SPI flash, then serves 32-bit word reads    |
// | rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module spiflash_rdctl
  import spiflash_pkg::*;
#(
  parameter int CLKDIV  = 1,
  parameter int CS_IDLE = 4
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        valid,
  output logic        ready,
  input  logic [23:0] addr,
  output logic [31:0] rdata,
  output logic        spi_cs,
  output logic        spi_sclk,
  output logic        spi_mosi,
  input  logic        spi_miso
);

  state_t      r_state, w_next;
  logic        r_cs, w_cs_nxt;
  logic [7:0]  r_gap, w_gap_nxt;
  logic        r_ready, w_ready_nxt;
  logic [31:0] r_rdata, w_rdata_nxt;
  logic        w_start;
  logic [6:0]  w_nbits;
  logic [31:0] w_tx;
  logic        w_busy;
  logic        w_done;
  logic [31:0] w_rx;

  spiflash_shift #(.CLKDIV(CLKDIV)) u_shift (
    .clk     (clk),
    .resetn  (resetn),
    .start   (w_start),
    .nbits   (w_nbits),
    .tx_data (w_tx),
    .miso    (spi_miso),
    .sclk    (spi_sclk),
    .mosi    (spi_mosi),
    .busy    (w_busy),
    .done    (w_done),
    .rx_data (w_rx)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= WAKE;
      r_cs    <= 1'b1;
      r_gap   <= 8'd0;
      r_ready <= 1'b0;
      r_rdata <= 32'd0;
    end else begin
      r_state <= w_next;
      r_cs    <= w_cs_nxt;
      r_gap   <= w_gap_nxt;
      r_ready <= w_ready_nxt;
      r_rdata <= w_rdata_nxt;
    end
  end

  always_comb begin
    w_next      = r_state;
    w_cs_nxt    = r_cs;
    w_gap_nxt   = 8'd0;
    w_ready_nxt = 1'b0;
    w_rdata_nxt = r_rdata;
    w_start     = 1'b0;
    w_nbits     = XFER_BITS;
    // Word-aligned address; the low two bits are forced to zero.
    w_tx        = {CMD_READ, addr[23:2], addr[1:0] & 2'b00};
    case (r_state)
      WAKE: begin
        w_nbits = WAKE_BITS;
        w_tx    = {CMD_WAKE, 24'h000000};
        // Chip select still high means the wake command has not started.
        if (r_cs && !w_busy) begin
          w_start  = 1'b1;
          w_cs_nxt = 1'b0;
        end else if (w_done) begin
          w_cs_nxt = 1'b1;
          w_next   = GAP;
        end
      end
      GAP: begin
        if (r_gap == 8'(CS_IDLE - 1)) w_next = IDLE;
        else                          w_gap_nxt = r_gap + 8'd1;
      end
      IDLE: begin
        if (valid) begin
          w_start  = 1'b1;
          w_cs_nxt = 1'b0;
          w_next   = XFER;
        end
      end
      XFER: begin
        if (w_done) begin
          w_cs_nxt    = 1'b1;
          w_ready_nxt = 1'b1;
          w_rdata_nxt = bswap32(w_rx);
          w_next      = DONE;
        end
      end
      DONE:    w_next = GAP;
      default: w_next = WAKE;
    endcase
  end

  assign spi_cs = r_cs;
  assign ready  = r_ready;
  assign rdata  = r_rdata;

endmodule

`default_nettype wire

// File: doc/spiflash_rdctl.md
SPIFLASH_RDCTL -- requirements
Module: spiflash_rdctl

Interface
REQ-001 SHALL have parameter CLKDIV, default 1: spi_sclk half-period in clk cycles, legal range 1..255.
REQ-002 SHALL have parameter CS_IDLE, default 4: minimum clk cycles spi_cs is held high between transfers, legal range 1..255.
REQ-003 clk  input  1  sole clock; all logic on posedge clk.
REQ-004 resetn  input  1  asynchronous, active-low reset.
REQ-005 valid  input  1  read request; held high with addr stable until ready.
REQ-006 ready  output  1  one-cycle pulse; rdata valid in that cycle.
REQ-007 addr  input  24  flash byte address; bits [1:0] ignored.
REQ-008 rdata  output  32  read word, little-endian.
REQ-009 spi_cs  output  1  flash chip select, active-low.
REQ-010 spi_sclk  output  1  SPI clock, mode 0 (idles low).
REQ-011 spi_mosi  output  1  serial data to flash, MSB first.
REQ-012 spi_miso  input  1  serial data from flash.

Function
- REQ-013 States: WAKE, GAP, IDLE, XFER, DONE.
- REQ-014 After reset release: enter WAKE, drive spi_cs low, shift out 8'hAB, raise spi_cs, then enter GAP.
- REQ-015 GAP: hold spi_cs high for CS_IDLE cycles, then enter IDLE. Every spi_cs rising edge is followed by GAP.
- REQ-016 IDLE with valid=1: in the next cycle, drive spi_cs low and enter XFER. valid is ignored in WAKE and GAP.
- REQ-017 XFER: shift out 32 bits, {8'h03, addr[23:2], 2'b00}, then shift in 32 bits; 64 SCLK periods total with no gaps.
- REQ-018 Bit timing: each bit is CLKDIV cycles with spi_sclk low, then CLKDIV cycles with spi_sclk high.
- REQ-019 spi_mosi changes only while spi_sclk is low. spi_miso is sampled in the clk cycle in which spi_sclk goes 0->1.
- REQ-020 Received byte k (k=0..3, in arrival order) SHALL land in rdata[8k+7:8k]; each byte is MSB first.
- REQ-021 After the 64th high phase: spi_cs goes high, spi_sclk stays low, state DONE. ready=1 for exactly one cycle, then GAP.
- REQ-022 Latency: ready asserts exactly 1+128*CLKDIV cycles after the IDLE cycle that sampled valid=1.
- REQ-023 rdata SHALL hold its value until the next ready.
- REQ-024 valid dropping mid-XFER is a protocol violation; the transfer SHALL still complete and pulse ready.
- REQ-025 Address 0xFFFFFC is legal; address wrap is the flash's concern, not this block's.
- REQ-026 spi_mosi=0 whenever spi_cs is high.

Reset
- REQ-027 While resetn=0: spi_cs=1, spi_sclk=0, spi_mosi=0, ready=0, rdata=0. All counters are zero and state is WAKE, held without advancing.
- REQ-028 Reset asserted mid-XFER SHALL take effect immediately and asynchronously: spi_cs high, spi_sclk low.
- REQ-029 After any reset, the wake sequence SHALL repeat before the next read.

Structure
- REQ-030 Package spiflash_pkg SHALL hold the opcode constants (CMD_WAKE=8'hAB, CMD_READ=8'h03) and the state enum.
- REQ-031 One sub-module, spiflash_shift, SHALL own the CLKDIV divider, bit counter and shift register. It takes a start/length command, reports done, and is used for both WAKE and XFER.

Verification (bench connects the block to the behavioural SPI flash model with a preloaded memory)
- REQ-032 Reset release, CLKDIV=1 -> spi_cs low for 8 SCLK periods, mosi bits 10101011, then spi_cs high for >=4 cycles. No ready pulse.
- REQ-033 mem[0x10..0x13]=11,22,33,44; valid with addr=0x000010 -> mosi carries 03 00 00 10. rdata=0x44332211, ready pulses once, latency 129 cycles.
- REQ-034 addr=0x000013 -> transmitted address 0x000010, same rdata 0x44332211.
- REQ-035 valid held high across two reads (0x10, then 0x14) -> spi_cs high for >=CS_IDLE cycles between transfers. Two ready pulses, correct data for each.
- REQ-036 resetn low at bit 40 of XFER -> spi_cs=1 and spi_sclk=0 in the same timestep, no ready pulse. After release, the 0xAB wake repeats.
- REQ-037 CLKDIV=3 -> SCLK period 6 cycles, latency 385 cycles, rdata identical to CLKDIV=1.
